// File: rtl/matrix_row_scanner_if.sv
// Bus between the frame composer and the LED matrix row scanner.
// master = frame source / matrix-side observer, slave = the scanner itself.
interface matrix_row_scanner_if;
   logic [191:0] frame_in;
   logic         frame_valid;
   logic         frame_ack;
   logic         sdi;
   logic         sclk;
   logic         rclk;
   logic         oe_n;
   logic [11:0]  row_sel;
   logic [3:0]   row_idx;

   modport master (
      output frame_in, frame_valid,
      input  frame_ack, sdi, sclk, rclk, oe_n, row_sel, row_idx
   );

   modport slave (
      input  frame_in, frame_valid,
      output frame_ack, sdi, sclk, rclk, oe_n, row_sel, row_idx
   );
endinterface

// File: rtl/matrix_row_scanner.sv
// LED dot-matrix row scanner: double-buffers a 12x16 frame and scans it row by
// row into 74HC595-style column drivers (shift, latch, then light the row).
// All outputs are registered and aligned with the FSM state they belong to.
module matrix_row_scanner #(
   parameter int DWELL_CYCLES = 2000,
   parameter int ROWS         = 12,
   parameter int COLS         = 16
) (
   input logic               clk,
   input logic               rst,
   matrix_row_scanner_if.slave bus
);

   localparam int FRAME_W = ROWS * COLS;
   localparam int DW_W    = $clog2(DWELL_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      LATCH = 3'd3,
      DWELL = 3'd4
   } state_t;

   state_t               state_r;
   state_t               state_next_s;
   logic [FRAME_W-1:0]   shadow_r;
   logic [FRAME_W-1:0]   active_r;
   logic                 pending_r;
   logic                 swap_s;
   logic [15:0]          row_data_s;
   logic [15:0]          shift_r;
   logic [3:0]           bit_cnt_r;
   logic                 phase_r;
   logic [DW_W-1:0]      dwell_cnt_r;
   logic [3:0]           row_idx_r;
   logic                 sdi_r;
   logic                 sclk_r;
   logic                 rclk_r;
   logic                 oe_n_r;
   logic [11:0]          row_sel_r;
   logic                 frame_ack_r;

   // Row r occupies frame[191-16*r -: 16]; column c is bit c of that slice.
   function automatic logic [15:0] row_slice(input logic [FRAME_W-1:0] frame,
                                             input logic [3:0] idx);
      logic [7:0] base;
      base = {4'd11 - idx, 4'b0000};
      return frame[base +: 16];
   endfunction

   // Next-state logic plus the row-0 buffer swap decision and row data source.
   always_comb begin
      state_next_s = state_r;
      swap_s       = 1'b0;
      row_data_s   = 16'h0000;
      case (state_r)
         IDLE:  state_next_s = LOAD;
         LOAD:  state_next_s = SHIFT;
         SHIFT: begin
            if (phase_r && (bit_cnt_r == 4'd0)) begin
               state_next_s = LATCH;
            end else begin
               state_next_s = SHIFT;
            end
         end
         LATCH: state_next_s = DWELL;
         DWELL: begin
            if (dwell_cnt_r == '0) begin
               state_next_s = LOAD;
            end else begin
               state_next_s = DWELL;
            end
         end
         default: state_next_s = IDLE;
      endcase
      // The swap row is loaded straight from the shadow so it is shown this frame.
      swap_s = (state_r == LOAD) && (row_idx_r == 4'd0) && pending_r;
      if (swap_s) begin
         row_data_s = row_slice(shadow_r, row_idx_r);
      end else begin
         row_data_s = row_slice(active_r, row_idx_r);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Shadow capture; a new strobe wins over the pending-clear of a swap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_r  <= '0;
         pending_r <= 1'b0;
      end else if (bus.frame_valid) begin
         shadow_r  <= bus.frame_in;
         pending_r <= 1'b1;
      end else if (swap_s) begin
         pending_r <= 1'b0;
      end
   end

   // Active buffer only changes at the row-0 load, so a frame never tears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_r <= '0;
      end else if (swap_s) begin
         active_r <= shadow_r;
      end
   end

   // Scan datapath: row index, serial shifter, bit/phase and dwell counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_idx_r   <= 4'd0;
         shift_r     <= 16'h0000;
         bit_cnt_r   <= 4'd0;
         phase_r     <= 1'b0;
         dwell_cnt_r <= '0;
         sdi_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: row_idx_r <= 4'd0;
            LOAD: begin
               // Col 15 goes out first; it is presented during the first phase A.
               sdi_r     <= row_data_s[15];
               shift_r   <= {row_data_s[14:0], 1'b0};
               bit_cnt_r <= 4'd15;
               phase_r   <= 1'b0;
            end
            SHIFT: begin
               if (!phase_r) begin
                  phase_r <= 1'b1;
               end else begin
                  phase_r <= 1'b0;
                  if (bit_cnt_r != 4'd0) begin
                     bit_cnt_r <= bit_cnt_r - 4'd1;
                     sdi_r     <= shift_r[15];
                     shift_r   <= {shift_r[14:0], 1'b0};
                  end
               end
            end
            LATCH: dwell_cnt_r <= DW_W'(DWELL_CYCLES - 1);
            DWELL: begin
               if (dwell_cnt_r == '0) begin
                  if (row_idx_r == 4'(ROWS - 1)) begin
                     row_idx_r <= 4'd0;
                  end else begin
                     row_idx_r <= row_idx_r + 4'd1;
                  end
               end else begin
                  dwell_cnt_r <= dwell_cnt_r - 1'b1;
               end
            end
            default: row_idx_r <= 4'd0;
         endcase
      end
   end

   // Driver control outputs, registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_r      <= 1'b0;
         rclk_r      <= 1'b0;
         oe_n_r      <= 1'b1;
         row_sel_r   <= 12'h000;
         frame_ack_r <= 1'b0;
      end else begin
         sclk_r      <= (state_r == SHIFT) && !phase_r;
         rclk_r      <= (state_next_s == LATCH);
         oe_n_r      <= (state_next_s != DWELL);
         row_sel_r   <= (state_next_s == DWELL) ? (12'd1 << row_idx_r) : 12'h000;
         frame_ack_r <= swap_s;
      end
   end

   assign bus.sdi       = sdi_r;
   assign bus.sclk      = sclk_r;
   assign bus.rclk      = rclk_r;
   assign bus.oe_n      = oe_n_r;
   assign bus.row_sel   = row_sel_r;
   assign bus.row_idx   = row_idx_r;
   assign bus.frame_ack = frame_ack_r;

endmodule
